// File: rtl/sd_rw_multisec_test_if.sv
// Bundles the SD self-test generator's control, sector port and status signals.
// The generator uses the master modport; the SD controller / board side uses slave.
interface sd_rw_multisec_test_if #(
    parameter int DATA_W = 16,
    parameter int ERR_W  = 16
);
    logic              sd_init_done;
    logic              start;
    logic              wr_busy;
    logic              wr_req;
    logic              wr_start_en;
    logic [31:0]       wr_sec_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_busy;
    logic              rd_val_en;
    logic [DATA_W-1:0] rd_val_data;
    logic              rd_start_en;
    logic [31:0]       rd_sec_addr;
    logic [ERR_W-1:0]  err_cnt;
    logic              test_done;
    logic              error_flag;

    modport master (
        input  sd_init_done, start, wr_busy, wr_req, rd_busy, rd_val_en, rd_val_data,
        output wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr,
        output err_cnt, test_done, error_flag
    );

    modport slave (
        output sd_init_done, start, wr_busy, wr_req, rd_busy, rd_val_en, rd_val_data,
        input  wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr,
        input  err_cnt, test_done, error_flag
    );
endinterface

// File: rtl/sd_rw_multisec_test.sv
// Multi-sector SD write/read-back self-test with mismatch and short/extra-sector counting.
// Optional build macro SD_TEST_LFSR_EN selects an LFSR data pattern instead of a ramp.
module sd_rw_multisec_test #(
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_SEC = 256,
    parameter int SEC_NUM       = 4,
    parameter int START_ADDR    = 2000,
    parameter int ERR_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sd_rw_multisec_test_if.master    bus
);
    localparam logic [2:0] IDLE_C    = 3'd0;
    localparam logic [2:0] WR_GO_C   = 3'd1;
    localparam logic [2:0] WR_WAIT_C = 3'd2;
    localparam logic [2:0] RD_GO_C   = 3'd3;
    localparam logic [2:0] RD_WAIT_C = 3'd4;
    localparam logic [2:0] DONE_C    = 3'd5;

    localparam logic [31:0] WPS_C      = 32'(WORDS_PER_SEC);
    localparam logic [31:0] START_C    = 32'(START_ADDR);
    localparam logic [15:0] SEC_LAST_C = 16'(SEC_NUM - 1);
    localparam logic [32:0] ERR_MAX_C  = 33'((64'd1 << ERR_W) - 64'd1);

    logic [2:0]        state_q;
    logic [15:0]       sec_idx_q;
    logic [31:0]       word_idx_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic              wr_start_q, rd_start_q, test_done_q, error_flag_q;
    logic [31:0]       wr_addr_q, rd_addr_q;
    logic [1:0]        init_sync_q, wrb_sync_q, rdb_sync_q;
    logic              init_prev_q, wrb_prev_q, rdb_prev_q;

    logic              idle_like_s, trigger_s, wr_fall_s, rd_fall_s;
    logic [DATA_W-1:0] pattern_s;
    logic              mismatch_s;
    logic [31:0]       words_seen_s, missing_s, word_inc_s;
    logic [32:0]       err_sum_s;
    logic [ERR_W-1:0]  err_d;

`ifdef SD_TEST_LFSR_EN
    logic [15:0] lfsr_q;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    assign pattern_s = DATA_W'(lfsr_q);
`else
    logic [31:0] ramp_s;
    assign ramp_s    = (32'(sec_idx_q) * WPS_C) + word_idx_q;
    assign pattern_s = DATA_W'(ramp_s);
`endif

    assign idle_like_s = (state_q == IDLE_C) || (state_q == DONE_C);
    assign trigger_s   = idle_like_s &&
                         ((init_sync_q[1] && !init_prev_q) || (bus.start && init_sync_q[1]));
    assign wr_fall_s   = wrb_prev_q && !wrb_sync_q[1];
    assign rd_fall_s   = rdb_prev_q && !rdb_sync_q[1];

    // A word arriving together with the busy fall is counted before the missing words.
    assign mismatch_s   = bus.rd_val_en &&
                          ((word_idx_q >= WPS_C) || (bus.rd_val_data != pattern_s));
    assign words_seen_s = word_idx_q + 32'(bus.rd_val_en);
    assign missing_s    = (rd_fall_s && (words_seen_s < WPS_C)) ? (WPS_C - words_seen_s) : 32'd0;
    assign err_sum_s    = 33'(err_cnt_q) + 33'(missing_s) + 33'(mismatch_s);
    assign err_d        = (err_sum_s > ERR_MAX_C) ? {ERR_W{1'b1}} : err_sum_s[ERR_W-1:0];
    assign word_inc_s   = (word_idx_q == 32'hFFFF_FFFF) ? word_idx_q : (word_idx_q + 32'd1);

    assign bus.wr_start_en = wr_start_q;
    assign bus.rd_start_en = rd_start_q;
    assign bus.wr_sec_addr = wr_addr_q;
    assign bus.rd_sec_addr = rd_addr_q;
    assign bus.wr_data     = pattern_s;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.test_done   = test_done_q;
    assign bus.error_flag  = error_flag_q;

    // Two-stage synchronisers plus edge history; init resets high so a reset with
    // sd_init_done already asserted does not look like a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_sync_q <= 2'b11;
            init_prev_q <= 1'b1;
            wrb_sync_q  <= 2'b00;
            wrb_prev_q  <= 1'b0;
            rdb_sync_q  <= 2'b00;
            rdb_prev_q  <= 1'b0;
        end else begin
            init_sync_q <= {init_sync_q[0], bus.sd_init_done};
            init_prev_q <= init_sync_q[1];
            wrb_sync_q  <= {wrb_sync_q[0], bus.wr_busy};
            wrb_prev_q  <= wrb_sync_q[1];
            rdb_sync_q  <= {rdb_sync_q[0], bus.rd_busy};
            rdb_prev_q  <= rdb_sync_q[1];
        end
    end

    // Test sequencer: write all sectors, read them back, then report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE_C;
            sec_idx_q    <= 16'd0;
            word_idx_q   <= 32'd0;
            err_cnt_q    <= {ERR_W{1'b0}};
            wr_start_q   <= 1'b0;
            rd_start_q   <= 1'b0;
            wr_addr_q    <= 32'd0;
            rd_addr_q    <= 32'd0;
            test_done_q  <= 1'b0;
            error_flag_q <= 1'b1;
`ifdef SD_TEST_LFSR_EN
            lfsr_q       <= 16'd0;
`endif
        end else begin
            wr_start_q <= 1'b0;
            rd_start_q <= 1'b0;
            case (state_q)
                IDLE_C, DONE_C: begin
                    if (trigger_s) begin
                        state_q      <= WR_GO_C;
                        sec_idx_q    <= 16'd0;
                        err_cnt_q    <= {ERR_W{1'b0}};
                        test_done_q  <= 1'b0;
                        error_flag_q <= 1'b1;
                    end
                end
                WR_GO_C: begin
                    wr_start_q <= 1'b1;
                    wr_addr_q  <= START_C + 32'(sec_idx_q);
                    word_idx_q <= 32'd0;
`ifdef SD_TEST_LFSR_EN
                    lfsr_q     <= 16'hACE1 ^ sec_idx_q;
`endif
                    state_q    <= WR_WAIT_C;
                end
                WR_WAIT_C: begin
                    if (bus.wr_req) begin
                        word_idx_q <= word_inc_s;
`ifdef SD_TEST_LFSR_EN
                        lfsr_q     <= lfsr_step(lfsr_q);
`endif
                    end
                    if (wr_fall_s) begin
                        if (sec_idx_q != SEC_LAST_C) begin
                            sec_idx_q <= sec_idx_q + 16'd1;
                            state_q   <= WR_GO_C;
                        end else begin
                            sec_idx_q <= 16'd0;
                            state_q   <= RD_GO_C;
                        end
                    end
                end
                RD_GO_C: begin
                    rd_start_q <= 1'b1;
                    rd_addr_q  <= START_C + 32'(sec_idx_q);
                    word_idx_q <= 32'd0;
`ifdef SD_TEST_LFSR_EN
                    lfsr_q     <= 16'hACE1 ^ sec_idx_q;
`endif
                    state_q    <= RD_WAIT_C;
                end
                RD_WAIT_C: begin
                    err_cnt_q <= err_d;
                    if (bus.rd_val_en) begin
                        word_idx_q <= word_inc_s;
`ifdef SD_TEST_LFSR_EN
                        lfsr_q     <= lfsr_step(lfsr_q);
`endif
                    end
                    if (rd_fall_s) begin
                        if (sec_idx_q != SEC_LAST_C) begin
                            sec_idx_q <= sec_idx_q + 16'd1;
                            state_q   <= RD_GO_C;
                        end else begin
                            state_q      <= DONE_C;
                            test_done_q  <= 1'b1;
                            error_flag_q <= (err_d != {ERR_W{1'b0}});
                        end
                    end
                end
                default: begin
                    state_q <= IDLE_C;
                end
            endcase
        end
    end
endmodule
